// File: rtl/qspi_resp_pkg.sv
// Shared definitions for the QSPI memory responder: FSM states, default
// command codes and phase lengths in nibbles.
package qspi_resp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_DUMMY  = 3'd3,
    ST_READ   = 3'd4,
    ST_WRITE  = 3'd5,
    ST_IGNORE = 3'd6
  } state_e;

  localparam logic [7:0] CMD_READ_DEFAULT  = 8'h0B;
  localparam logic [7:0] CMD_WRITE_DEFAULT = 8'h02;

  localparam logic [3:0] CMD_NIBBLES  = 4'd2;
  localparam logic [3:0] ADDR_NIBBLES = 4'd6;

endpackage

// File: rtl/qspi_edge_sync.sv
// Brings the asynchronous SPI clock, chip select and data into the clk domain
// and turns SPI clock transitions into single-cycle rise/fall events.
module qspi_edge_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_clk_in,
  input  logic       spi_cs_n,
  input  logic [3:0] spi_data_in,
  output logic       sclk_rise,
  output logic       sclk_fall,
  output logic       cs_n_sync,
  output logic [3:0] data_sync
);

  logic [1:0] sclk_sync_r;
  logic       sclk_prev_r;
  logic [1:0] cs_sync_r;
  logic [3:0] data_meta_r;
  logic [3:0] data_sync_r;

  // Two-flop synchronisers; data gets the same two-stage delay so it lines up with the clock event
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_r <= 2'b00;
      sclk_prev_r <= 1'b0;
      cs_sync_r   <= 2'b11;
      data_meta_r <= 4'h0;
      data_sync_r <= 4'h0;
    end else begin
      sclk_sync_r <= {sclk_sync_r[0], spi_clk_in};
      sclk_prev_r <= sclk_sync_r[1];
      cs_sync_r   <= {cs_sync_r[0], spi_cs_n};
      data_meta_r <= spi_data_in;
      data_sync_r <= data_meta_r;
    end
  end

  assign sclk_rise = sclk_sync_r[1] & ~sclk_prev_r;
  assign sclk_fall = ~sclk_sync_r[1] & sclk_prev_r;
  assign cs_n_sync = cs_sync_r[1];
  assign data_sync = data_sync_r;

endmodule

// File: rtl/qspi_mem_responder.sv
// Quad-SPI target that serves controller read/write commands from a simple
// byte-wide synchronous memory port, oversampling the SPI clock with clk.
module qspi_mem_responder
  import qspi_resp_pkg::*;
#(
  parameter int         ADDR_W       = 24,
  parameter int         DUMMY_CYCLES = 4,
  parameter logic [7:0] CMD_READ     = CMD_READ_DEFAULT,
  parameter logic [7:0] CMD_WRITE    = CMD_WRITE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_clk_in,
  input  logic              spi_cs_n,
  input  logic [3:0]        spi_data_in,
  output logic [3:0]        spi_data_out,
  output logic [3:0]        spi_data_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_req,
  input  logic [7:0]        mem_rd_data,
  input  logic              mem_rd_valid,
  output logic              mem_wr_en,
  output logic [7:0]        mem_wr_data,
  output logic              err_underrun
);

  localparam logic [ADDR_W-1:0] ADDR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [3:0]        DUMMY_LAST = 4'(DUMMY_CYCLES - 1);

  logic        sclk_rise_s;
  logic        sclk_fall_s;
  logic        cs_n_sync_s;
  logic [3:0]  data_sync_s;

  state_e            state_r, state_s;
  logic [3:0]        cnt_r, cnt_s;
  logic [19:0]       shift_r, shift_s;
  logic              is_wr_r, is_wr_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic              rd_req_r, rd_req_s;
  logic              wr_en_r, wr_en_s;
  logic [7:0]        wr_data_r, wr_data_s;
  logic [7:0]        buf_r, buf_s;
  logic              buf_valid_r, buf_valid_s;
  logic [3:0]        lo_r, lo_s;
  logic              lo_valid_r, lo_valid_s;
  logic              pend_r, pend_s;
  logic              hi_phase_r, hi_phase_s;
  logic [3:0]        dout_r, dout_s;
  logic              oe_r, oe_s;
  logic              err_r, err_s;
  logic [7:0]        code_s;
  logic [23:0]       addr_full_s;

  qspi_edge_sync u_edge_sync (
    .clk         (clk),
    .rst         (rst),
    .spi_clk_in  (spi_clk_in),
    .spi_cs_n    (spi_cs_n),
    .spi_data_in (spi_data_in),
    .sclk_rise   (sclk_rise_s),
    .sclk_fall   (sclk_fall_s),
    .cs_n_sync   (cs_n_sync_s),
    .data_sync   (data_sync_s)
  );

  assign code_s      = {shift_r[3:0], data_sync_s};
  assign addr_full_s = {shift_r, data_sync_s};

  // Next-state and next-output logic for the whole transaction sequencer
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    shift_s     = shift_r;
    is_wr_s     = is_wr_r;
    addr_s      = addr_r;
    rd_req_s    = 1'b0;
    wr_en_s     = 1'b0;
    wr_data_s   = wr_data_r;
    buf_s       = buf_r;
    buf_valid_s = buf_valid_r;
    lo_s        = lo_r;
    lo_valid_s  = lo_valid_r;
    pend_s      = pend_r;
    hi_phase_s  = hi_phase_r;
    dout_s      = dout_r;
    oe_s        = oe_r;
    err_s       = err_r;

    // The address advances in the cycle after a write strobe is presented
    if (wr_en_r) begin
      addr_s = addr_r + ADDR_ONE;
    end else begin
      addr_s = addr_r;
    end

    if (mem_rd_valid && pend_r) begin
      buf_s       = mem_rd_data;
      buf_valid_s = 1'b1;
      pend_s      = 1'b0;
    end else begin
      buf_s = buf_r;
    end

    if (cs_n_sync_s) begin
      state_s     = ST_IDLE;
      cnt_s       = 4'd0;
      oe_s        = 1'b0;
      dout_s      = 4'h0;
      pend_s      = 1'b0;
      buf_valid_s = 1'b0;
      lo_valid_s  = 1'b0;
      hi_phase_s  = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_s = ST_CMD;
          cnt_s   = 4'd0;
        end
        ST_CMD: begin
          if (sclk_rise_s) begin
            shift_s = {shift_r[15:0], data_sync_s};
            if (cnt_r == CMD_NIBBLES - 4'd1) begin
              cnt_s = 4'd0;
              if (code_s == CMD_READ) begin
                state_s = ST_ADDR;
                is_wr_s = 1'b0;
              end else if (code_s == CMD_WRITE) begin
                state_s = ST_ADDR;
                is_wr_s = 1'b1;
              end else begin
                state_s = ST_IGNORE;
              end
            end else begin
              cnt_s = cnt_r + 4'd1;
            end
          end else begin
            cnt_s = cnt_r;
          end
        end
        ST_ADDR: begin
          if (sclk_rise_s) begin
            shift_s = {shift_r[15:0], data_sync_s};
            if (cnt_r == ADDR_NIBBLES - 4'd1) begin
              cnt_s  = 4'd0;
              addr_s = addr_full_s[ADDR_W-1:0];
              if (is_wr_r) begin
                state_s    = ST_WRITE;
                hi_phase_s = 1'b1;
              end else begin
                state_s     = ST_DUMMY;
                rd_req_s    = 1'b1;
                pend_s      = 1'b1;
                buf_valid_s = 1'b0;
              end
            end else begin
              cnt_s = cnt_r + 4'd1;
            end
          end else begin
            cnt_s = cnt_r;
          end
        end
        ST_DUMMY: begin
          if (sclk_rise_s) begin
            if (cnt_r == DUMMY_LAST) begin
              cnt_s      = 4'd0;
              state_s    = ST_READ;
              hi_phase_s = 1'b1;
            end else begin
              cnt_s = cnt_r + 4'd1;
            end
          end else begin
            cnt_s = cnt_r;
          end
        end
        ST_READ: begin
          // The low nibble is parked in lo_r so the prefetch may refill buf_r early
          if (sclk_fall_s) begin
            oe_s = 1'b1;
            if (hi_phase_r) begin
              if (buf_valid_r) begin
                dout_s     = buf_r[7:4];
                lo_s       = buf_r[3:0];
                lo_valid_s = 1'b1;
              end else begin
                dout_s     = 4'h0;
                err_s      = 1'b1;
                lo_valid_s = 1'b0;
              end
              addr_s      = addr_r + ADDR_ONE;
              rd_req_s    = 1'b1;
              pend_s      = 1'b1;
              buf_valid_s = 1'b0;
              hi_phase_s  = 1'b0;
            end else begin
              if (lo_valid_r) begin
                dout_s = lo_r;
              end else begin
                dout_s = 4'h0;
                err_s  = 1'b1;
              end
              lo_valid_s = 1'b0;
              hi_phase_s = 1'b1;
            end
          end else begin
            oe_s = oe_r;
          end
        end
        ST_WRITE: begin
          if (sclk_rise_s) begin
            if (hi_phase_r) begin
              shift_s    = {shift_r[15:0], data_sync_s};
              hi_phase_s = 1'b0;
            end else begin
              wr_data_s  = {shift_r[3:0], data_sync_s};
              wr_en_s    = 1'b1;
              hi_phase_s = 1'b1;
            end
          end else begin
            wr_en_s = 1'b0;
          end
        end
        ST_IGNORE: begin
          state_s = ST_IGNORE;
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 4'd0;
      shift_r     <= 20'h0;
      is_wr_r     <= 1'b0;
      addr_r      <= {ADDR_W{1'b0}};
      rd_req_r    <= 1'b0;
      wr_en_r     <= 1'b0;
      wr_data_r   <= 8'h00;
      buf_r       <= 8'h00;
      buf_valid_r <= 1'b0;
      lo_r        <= 4'h0;
      lo_valid_r  <= 1'b0;
      pend_r      <= 1'b0;
      hi_phase_r  <= 1'b1;
      dout_r      <= 4'h0;
      oe_r        <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      shift_r     <= shift_s;
      is_wr_r     <= is_wr_s;
      addr_r      <= addr_s;
      rd_req_r    <= rd_req_s;
      wr_en_r     <= wr_en_s;
      wr_data_r   <= wr_data_s;
      buf_r       <= buf_s;
      buf_valid_r <= buf_valid_s;
      lo_r        <= lo_s;
      lo_valid_r  <= lo_valid_s;
      pend_r      <= pend_s;
      hi_phase_r  <= hi_phase_s;
      dout_r      <= dout_s;
      oe_r        <= oe_s;
      err_r       <= err_s;
    end
  end

  assign spi_data_out = dout_r;
  assign spi_data_oe  = {4{oe_r}};
  assign mem_addr     = addr_r;
  assign mem_rd_req   = rd_req_r;
  assign mem_wr_en    = wr_en_r;
  assign mem_wr_data  = wr_data_r;
  assign err_underrun = err_r;

endmodule
